// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the ALU/register-file/RAM datapath.
// Decodes one instruction per handshake and walks EXEC/MEM/WB, driving datapath controls.
module datapath_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  readA,
  output logic [4:0]  readB,
  output logic [4:0]  writeReg,
  output logic [4:0]  sel,
  output logic        cin,
  output logic        muxSel,
  output logic        write,
  output logic        writeRam,
  input  logic [3:0]  status,
  input  logic        Cout,
  output logic [4:0]  flags,
  output logic [15:0] retired,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_HALT  = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  read_a_q, read_a_d;
  logic [4:0]  read_b_q, read_b_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [4:0]  sel_q, sel_d;
  logic        cin_q, cin_d;
  logic        mux_sel_q, mux_sel_d;
  logic [4:0]  flags_q, flags_d;
  logic [15:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        accept;
  logic        unused_low_bits;

  assign unused_low_bits = ^instr[6:0];

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // upstream must hold instr stable until then. Ready is only offered in IDLE, never under reset.
  assign instr_ready = (state_q == S_IDLE) && !reset;
  assign accept      = (state_q == S_IDLE) && instr_valid;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    read_a_d    = read_a_q;
    read_b_d    = read_b_q;
    write_reg_d = write_reg_q;
    sel_d       = sel_q;
    cin_d       = cin_q;
    mux_sel_d   = mux_sel_q;
    flags_d     = flags_q;
    retired_d   = retired_q;
    illegal_d   = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = instr[31:28];
          unique case (instr[31:28])
            OP_ALU, OP_STORE, OP_LOAD: begin
              state_d     = S_EXEC;
              write_reg_d = instr[27:23];
              read_a_d    = instr[22:18];
              read_b_d    = instr[17:13];
              sel_d       = instr[12:8];
              cin_d       = instr[7];
              mux_sel_d   = (instr[31:28] == OP_LOAD);
            end
            OP_HALT: state_d = S_HALT;
            OP_NOP:  retired_d = retired_q + 16'd1;
            default: begin
              retired_d = retired_q + 16'd1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        flags_d = {Cout, status};
        state_d = (op_q == OP_ALU) ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (op_q == OP_STORE) begin
          retired_d = retired_q + 16'd1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retired_d = retired_q + 16'd1;
        state_d   = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 4'd0;
      read_a_q    <= 5'd0;
      read_b_q    <= 5'd0;
      write_reg_q <= 5'd0;
      sel_q       <= 5'd0;
      cin_q       <= 1'b0;
      mux_sel_q   <= 1'b0;
      flags_q     <= 5'd0;
      retired_q   <= 16'd0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      read_a_q    <= read_a_d;
      read_b_q    <= read_b_d;
      write_reg_q <= write_reg_d;
      sel_q       <= sel_d;
      cin_q       <= cin_d;
      mux_sel_q   <= mux_sel_d;
      flags_q     <= flags_d;
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
    end
  end

  // Strobes decode straight from the state register, so each is a clean one-cycle pulse.
  assign write    = (state_q == S_WB);
  assign writeRam = (state_q == S_MEM) && (op_q == OP_STORE);
  assign halted   = (state_q == S_HALT);
  assign readA    = read_a_q;
  assign readB    = read_b_q;
  assign writeReg = write_reg_q;
  assign sel      = sel_q;
  assign cin      = cin_q;
  assign muxSel   = mux_sel_q;
  assign flags    = flags_q;
  assign retired  = retired_q;
  assign illegal  = illegal_q;

endmodule
